// File: rtl/updown_cnt_pkg.sv
// Shared encodings and the load-clamp helper for updown_counter_n.
package updown_cnt_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic END_WRAP = 1'b0;
    localparam logic END_SAT  = 1'b1;

    // Load values above the range clamp to the top instead of being truncated.
    function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max);
        logic [31:0] res;
        if (d > max) begin
            res = max;
        end else begin
            res = d;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Step-tick generator: one tick every PRESCALE enabled cycles; clr restarts the period.
module cnt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_r;
    logic [PW-1:0] cnt_next_s;
    logic          tick_s;

    // Next prescaler value and tick decode.
    always_comb begin
        cnt_next_s = cnt_r;
        tick_s     = 1'b0;
        if (clr) begin
            cnt_next_s = {PW{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_next_s = {PW{1'b0}};
                tick_s     = 1'b1;
            end else begin
                cnt_next_s = cnt_r + PW'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {PW{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/updown_counter_n.sv
// Up/down counter with clamped parallel load, programmable modulus and wrap/saturate ends.
// Optional prescaler enabled by defining UPDOWN_CNT_PRESCALE_EN.
module updown_counter_n
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = MAX_VAL,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up_down,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] load_val_s;
    logic             wrap_r;
    logic             wrap_next_s;
    logic             tick_s;

`ifdef UPDOWN_CNT_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (en),
        .tick (tick_s)
    );
`else
    // PRESCALE is at least 1, so the tick is constant high here.
    assign tick_s = (PRESCALE > 0);
`endif

    assign load_val_s = WIDTH'(clamp_load(32'(d), 32'(MAX_VAL)));

    // Next count and wrap pulse; range ends are detected by compare, not overflow.
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        if (load) begin
            q_next_s = load_val_s;
        end else if (en && tick_s) begin
            if (up_down == DIR_UP) begin
                if (q_r < MAX_Q) begin
                    q_next_s = q_r + WIDTH'(1);
                end else if ((q_r == MAX_Q) && (sat == END_SAT)) begin
                    q_next_s = q_r;
                end else begin
                    q_next_s    = ZERO_Q;
                    wrap_next_s = 1'b1;
                end
            end else begin
                if (q_r != ZERO_Q) begin
                    q_next_s = q_r - WIDTH'(1);
                end else if (sat == END_SAT) begin
                    q_next_s = q_r;
                end else begin
                    q_next_s    = MAX_Q;
                    wrap_next_s = 1'b1;
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= RST_Q;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign q    = q_r;
    assign wrap = wrap_r;
    assign tc   = (up_down == DIR_UP) ? (q_r == MAX_Q) : (q_r == ZERO_Q);

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench: three counter configurations driven by shared stimulus vs. a reference model.
module tb_updown_counter_n;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] d;
    logic       up_down;
    logic       sat;

    logic [3:0] q_o [3];
    logic       tc_o [3];
    logic       wrap_o [3];

    int checks_cnt;
    int fail_cnt;

    localparam int MAXV [3] = '{15, 9, 9};
    localparam int RSTV [3] = '{15, 0, 2};
`ifdef UPDOWN_CNT_PRESCALE_EN
    localparam int PSV  [3] = '{1, 1, 3};
`else
    localparam int PSV  [3] = '{1, 1, 1};
`endif

    int m_q [3];
    int m_w [3];
    int m_p [3];

    updown_counter_n u_def (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .up_down(up_down), .sat(sat), .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_mod9 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .up_down(up_down), .sat(sat), .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(2), .PRESCALE(3)) u_ps3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .up_down(up_down), .sat(sat), .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic l, input logic e, input logic [3:0] dv,
                        input logic ud, input logic s);
        int nxt;
        reset = r; load = l; en = e; d = dv; up_down = ud; sat = s;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_q[i] = RSTV[i]; m_w[i] = 0; m_p[i] = 0;
            end else if (l) begin
                m_q[i] = (int'(dv) > MAXV[i]) ? MAXV[i] : int'(dv);
                m_w[i] = 0; m_p[i] = 0;
            end else if (e) begin
                m_w[i] = 0;
                if (m_p[i] == PSV[i] - 1) begin
                    m_p[i] = 0;
                    nxt = ud ? m_q[i] + 1 : m_q[i] - 1;
                    if (nxt < 0 || nxt > MAXV[i]) begin
                        if (s) begin
                            nxt = m_q[i];
                        end else begin
                            nxt = (nxt + MAXV[i] + 1) % (MAXV[i] + 1);
                            m_w[i] = 1;
                        end
                    end
                    m_q[i] = nxt;
                end else begin
                    m_p[i]++;
                end
            end else begin
                m_w[i] = 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("q[%0d]", i), 32'(q_o[i]), 32'(m_q[i]));
            check_val($sformatf("wrap[%0d]", i), 32'(wrap_o[i]), 32'(m_w[i]));
            check_val($sformatf("tc[%0d]", i), 32'(tc_o[i]),
                      (ud ? (m_q[i] == MAXV[i]) : (m_q[i] == 0)) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        reset = 1'b1; load = 1'b0; en = 1'b0; d = 4'd0; up_down = 1'b0; sat = 1'b0;

        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Default down-count through the wrap back to the top.
        for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        // Up-count across the modulus-10 wrap.
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 11; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        // Saturate at the top, then reverse direction.
        step(1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        // Saturate at zero going down.
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        // Clamped load, then load beating a simultaneous step.
        step(1'b0, 1'b1, 1'b0, 4'd13, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        // Reset mid-count, then enable low holds.
        step(1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        // Prescaled run with a load restarting the period mid-way.
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
